// File: rtl/idex_stage_reg.sv
// ---------------------------------------------------------------------------
// idex_stage_reg
//
// ID/EX pipeline boundary of the in-order MIPS core. It captures each decoded
// instruction (PC, instruction word, opaque control bundle, jump/branch class
// bits), tags instructions that sit in a branch delay slot, and computes the
// exception EPC for them.
//
// Both sides use a valid/ready handshake. A one-entry skid buffer sits behind
// the output slot, so id_ready comes straight from a flop and does not depend
// combinationally on ex_ready.
//
// Ports:
//   clk, rst          core clock (rising edge), asynchronous active-high reset
//   flush             exception/ERET flush; drops held and incoming entries
//   id_valid/id_ready upstream handshake (id_ready = NOT skid valid)
//   id_pc, id_instr, id_ctrl, id_is_jmp, id_is_jr, id_is_branch
//                     decoded instruction fields
//   ex_valid/ex_ready downstream handshake
//   ex_pc, ex_instr, ex_ctrl, ex_is_jmp, ex_is_jr, ex_is_branch
//                     contents of the output slot
//   ex_in_delay_slot  instruction follows an accepted control transfer
//   ex_epc            ex_pc-4 for delay-slot instructions, else ex_pc
//
// Optional feature (macro IDEX_PERF_CNT_EN):
//   perf_stall_cnt    saturating count of cycles with ex_valid & !ex_ready
//   perf_bubble_cnt   saturating count of cycles with !ex_valid & ex_ready
// ---------------------------------------------------------------------------
module idex_stage_reg #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [PC_W-1:0]    id_pc,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic               id_is_jmp,
  input  logic               id_is_jr,
  input  logic               id_is_branch,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [PC_W-1:0]    ex_pc,
  output logic [INSTR_W-1:0] ex_instr,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic               ex_is_jmp,
  output logic               ex_is_jr,
  output logic               ex_is_branch,
  output logic               ex_in_delay_slot,
  output logic [PC_W-1:0]    ex_epc
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
    logic               is_jmp;
    logic               is_jr;
    logic               is_branch;
    logic               ds;
  } entry_t;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ds_pending_q, ds_pending_d;

  entry_t in_entry;
  logic   acc;
  logic   deq;

  assign id_ready = ~skid_valid_q;
  assign acc      = id_valid & id_ready;
  assign deq      = out_valid_q & ex_ready;

  // Incoming entry inherits the delay-slot tag armed by the previous accept.
  always_comb begin
    in_entry.pc        = id_pc;
    in_entry.instr     = id_instr;
    in_entry.ctrl      = id_ctrl;
    in_entry.is_jmp    = id_is_jmp;
    in_entry.is_jr     = id_is_jr;
    in_entry.is_branch = id_is_branch;
    in_entry.ds        = ds_pending_q;
  end

  // Next-state logic for the two entries and the delay-slot tracker.
  // Flush wins over everything; a consumed instruction still counts as taken
  // because the downstream handshake completes regardless.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    ds_pending_d = ds_pending_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      ds_pending_d = 1'b0;
    end else begin
      if (acc) begin
        ds_pending_d = id_is_jmp | id_is_jr | id_is_branch;
      end

      if (!out_valid_q) begin
        if (acc) begin
          out_d       = in_entry;
          out_valid_d = 1'b1;
        end
      end else if (deq) begin
        if (skid_valid_q) begin
          // id_ready is low here, so no accept can collide with the refill.
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else if (acc) begin
          out_d = in_entry;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (!skid_valid_q && acc) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
  end

  // State registers; data is cleared on reset so outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ds_pending_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ds_pending_q <= ds_pending_d;
    end
  end

  assign ex_valid         = out_valid_q;
  assign ex_pc            = out_q.pc;
  assign ex_instr         = out_q.instr;
  assign ex_ctrl          = out_q.ctrl;
  assign ex_is_jmp        = out_q.is_jmp;
  assign ex_is_jr         = out_q.is_jr;
  assign ex_is_branch     = out_q.is_branch;
  assign ex_in_delay_slot = out_q.ds;
  // Subtraction wraps modulo 2^PC_W.
  assign ex_epc           = out_q.ds ? (out_q.pc - PC_W'(4)) : out_q.pc;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

  // Saturating counters; flush deliberately does not touch them.
  always_comb begin
    perf_stall_cnt_d  = perf_stall_cnt_q;
    perf_bubble_cnt_d = perf_bubble_cnt_q;
    if (out_valid_q && !ex_ready && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
    if (!out_valid_q && ex_ready && (perf_bubble_cnt_q != 32'hFFFF_FFFF)) begin
      perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_q  <= 32'd0;
      perf_bubble_cnt_q <= 32'd0;
    end else begin
      perf_stall_cnt_q  <= perf_stall_cnt_d;
      perf_bubble_cnt_q <= perf_bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_cnt_q;
  assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule
